// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-byte register file with two combinational
// read ports, one byte-enabled synchronous write port and a per-register
// busy scoreboard with a registered busy counter.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read
// forwarding on both read ports, data and busy flags).
module regfile_sb #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 3,
  localparam int BE_W   = DATA_W / 8,
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] w,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] r1,
  input  logic [ADDR_W-1:0] r2,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_w,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  // Byte-wise merge: bytes with an enable take the new data, others keep old.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [BE_W-1:0]   en
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int k = 0; k < BE_W; k++) begin
      if (en[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] regs_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic [ADDR_W:0]   cnt_r;
  logic [ADDR_W:0]   cnt_nxt_s;
  logic              set_new_s;
  logic              clr_s;
  logic [DATA_W-1:0] out1_s;
  logic [DATA_W-1:0] out2_s;
  logic              busy1_s;
  logic              busy2_s;

  // Register storage: byte-enabled write of the addressed entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      regs_r[w] <= merge_bytes(regs_r[w], in, be);
    end
  end

  // Next busy vector: writeback clears, issue sets, and set wins on a tie.
  always_comb begin
    busy_nxt_s = busy_r;
    if (we) begin
      busy_nxt_s[w] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (sb_set) begin
      busy_nxt_s[sb_w] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // Counter delta: only real 0->1 and 1->0 transitions move the count,
  // so re-setting a busy register or clearing an idle one never drifts it.
  always_comb begin
    set_new_s = sb_set & ~busy_r[sb_w];
    clr_s     = we & busy_r[w] & ~(sb_set & (sb_w == w));
    case ({set_new_s, clr_s})
      2'b10:   cnt_nxt_s = cnt_r + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   cnt_nxt_s = cnt_r - {{ADDR_W{1'b0}}, 1'b1};
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Scoreboard state and its population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NREG{1'b0}};
      cnt_r  <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Read ports: stored state, optionally overlaid with the in-flight write.
  always_comb begin
    out1_s  = regs_r[r1];
    out2_s  = regs_r[r2];
    busy1_s = busy_r[r1];
    busy2_s = busy_r[r2];
`ifdef REGFILE_BYPASS_EN
    if (we && (w == r1)) begin
      out1_s  = merge_bytes(regs_r[r1], in, be);
      busy1_s = 1'b0;
    end else begin
      out1_s  = out1_s;
    end
    if (we && (w == r2)) begin
      out2_s  = merge_bytes(regs_r[r2], in, be);
      busy2_s = 1'b0;
    end else begin
      out2_s  = out2_s;
    end
`endif
  end

  assign out1     = out1_s;
  assign out2     = out2_s;
  assign busy1    = busy1_s;
  assign busy2    = busy2_s;
  assign busy_cnt = cnt_r;

endmodule
